chip_sr_latch_tester: RTL and testbench

CHIP_SR_LATCH_TESTER -- requirements
Module: chip_sr_latch_tester

---
 rtl/chip_tester_pkg.sv | 38 +++
 rtl/chip_sr_latch_tester_if.sv | 29 ++
 rtl/bit_sync2.sv | 25 ++
 rtl/chip_sr_latch_tester.sv | 126 ++++++++++++
 tb/tb_chip_sr_latch_tester.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/chip_tester_pkg.sv
// rtl/chip_tester_pkg.sv - shared types and vector table for the SR-latch tester
// Purpose : state encoding, step count, "no failure" marker and the per-step
//           (S_n, R_n, expected Q) vector table, stored one bit per step.
// Ports   : none (package).
package chip_tester_pkg;

  typedef enum logic [2:0] {
    HALTED = 3'd0,
    INIT   = 3'd1,
    DRIVE  = 3'd2,
    SETTLE = 3'd3,
    SAMPLE = 3'd4,
    DONE_S = 3'd5
  } state_t;

  localparam int         NUM_STEPS = 7;
  localparam logic [2:0] FAIL_NONE = 3'd7;
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  // Bit k of each word is the value used in step k.
  //   step : 0 1 2 3 4 5 6
  //   S_n  : 0 1 1 1 0 1 0
  //   R_n  : 1 1 0 1 0 0 1
  //   Q    : 1 1 0 0 1 0 1
  localparam logic [NUM_STEPS-1:0] VEC_S_N = 7'b0101110;
  localparam logic [NUM_STEPS-1:0] VEC_R_N = 7'b1001011;
  localparam logic [NUM_STEPS-1:0] VEC_Q   = 7'b1010011;

  // Out-of-range step indices read as 1 so a stray index never drives a latch.
  function automatic logic vec_bit(input logic [NUM_STEPS-1:0] tbl,
                                   input logic [2:0]           idx);
    if (idx < 3'(NUM_STEPS)) begin
      return tbl[idx];
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/chip_sr_latch_tester_if.sv
// rtl/chip_sr_latch_tester_if.sv - control, device and result signals of the tester
// Purpose : bundles everything except clk/rst.
// Ports   : run, disp_rslt (host -> tester); dut_q (device -> tester);
//           drv_s_n, drv_r_n (tester -> device); done, rslt, fail_mask,
//           fail_step (tester -> host).
//           master = host/device side, slave = tester side.
interface chip_sr_latch_tester_if #(
  parameter int NUM_CH = 4
);
  logic              run;
  logic              disp_rslt;
  logic [NUM_CH-1:0] dut_q;
  logic [NUM_CH-1:0] drv_s_n;
  logic [NUM_CH-1:0] drv_r_n;
  logic              done;
  logic              rslt;
  logic [NUM_CH-1:0] fail_mask;
  logic [2:0]        fail_step;

  modport master (
    output run, disp_rslt, dut_q,
    input  drv_s_n, drv_r_n, done, rslt, fail_mask, fail_step
  );

  modport slave (
    input  run, disp_rslt, dut_q,
    output drv_s_n, drv_r_n, done, rslt, fail_mask, fail_step
  );
endinterface

// File: rtl/bit_sync2.sv
// rtl/bit_sync2.sv - two-flop synchronizer, parametrised width
// Purpose : brings an asynchronous bus into the clk domain.
// Ports   : clk, rst (async, active-high), d (async input), q (synchronized).
module bit_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/chip_sr_latch_tester.sv
// rtl/chip_sr_latch_tester.sv - functional tester for a bank of SR latches (74279 style)
// Purpose : on run, steps through a fixed 7-entry vector table, drives every
//           channel with the same S_n/R_n pair, waits SETTLE_CYC cycles and
//           compares the synchronized Q of each channel with the expected value.
// Ports   : clk, rst (async, active-high);
//           bus (slave): run, disp_rslt, dut_q in; drv_s_n, drv_r_n, done,
//           rslt, fail_mask, fail_step out.
module chip_sr_latch_tester
  import chip_tester_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SETTLE_CYC   = 4,
  parameter int STOP_ON_FAIL = 0
) (
  input logic                  clk,
  input logic                  rst,
  chip_sr_latch_tester_if.slave bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t            state;
  state_t            next_state;
  logic [2:0]        step;
  logic [2:0]        drive_step;
  logic [3:0]        settle_cnt;
  logic [NUM_CH-1:0] q_sync;
  logic [NUM_CH-1:0] mismatch;
  logic              any_fail;
  logic              exp_q;
  logic              vec_s_n;
  logic              vec_r_n;

  bit_sync2 #(.WIDTH(NUM_CH)) u_q_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.dut_q),
    .q   (q_sync)
  );

  assign exp_q    = vec_bit(VEC_Q, step);
  assign mismatch = q_sync ^ {NUM_CH{exp_q}};
  assign any_fail = |mismatch;

  // DRIVE is entered only from INIT (step 0) or SAMPLE (next step).
  assign drive_step = (state == SAMPLE) ? step + 3'd1 : 3'd0;
  assign vec_s_n    = vec_bit(VEC_S_N, drive_step);
  assign vec_r_n    = vec_bit(VEC_R_N, drive_step);

  assign bus.done = (state == DONE_S);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HALTED;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      HALTED: if (bus.run) next_state = INIT;
      INIT:   next_state = DRIVE;
      DRIVE:  next_state = SETTLE;
      SETTLE: if (settle_cnt == SETTLE_LAST) next_state = SAMPLE;
      SAMPLE: begin
        if (step == LAST_STEP || (STOP_ON_FAIL != 0 && any_fail)) begin
          next_state = DONE_S;
        end else begin
          next_state = DRIVE;
        end
      end
      // disp_rslt wins over run here, so a new test always needs a fresh HALTED cycle.
      DONE_S: if (bus.disp_rslt) next_state = HALTED;
      default: next_state = HALTED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step          <= 3'd0;
      settle_cnt    <= 4'd0;
      bus.drv_s_n   <= '1;
      bus.drv_r_n   <= '1;
      bus.rslt      <= 1'b0;
      bus.fail_mask <= '0;
      bus.fail_step <= FAIL_NONE;
    end else begin
      if (state == SETTLE && next_state == SETTLE) begin
        settle_cnt <= settle_cnt + 4'd1;
      end else begin
        settle_cnt <= 4'd0;
      end

      if (next_state == DRIVE) begin
        step <= drive_step;
      end

      // Drives are re-registered only when entering DRIVE; outside a test
      // they are parked inactive.
      if (next_state == DRIVE && state != DRIVE) begin
        bus.drv_s_n <= {NUM_CH{vec_s_n}};
        bus.drv_r_n <= {NUM_CH{vec_r_n}};
      end else if (next_state == HALTED || next_state == INIT || next_state == DONE_S) begin
        bus.drv_s_n <= '1;
        bus.drv_r_n <= '1;
      end

      if (state == INIT) begin
        bus.rslt      <= 1'b1;
        bus.fail_mask <= '0;
        bus.fail_step <= FAIL_NONE;
      end else if (state == SAMPLE) begin
        bus.fail_mask <= bus.fail_mask | mismatch;
        if (any_fail) begin
          bus.rslt <= 1'b0;
          if (bus.fail_step == FAIL_NONE) begin
            bus.fail_step <= step;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_chip_sr_latch_tester.sv
// tb/tb_chip_sr_latch_tester.sv - self-checking bench for chip_sr_latch_tester
module tb_chip_sr_latch_tester;

  localparam int NUM_CH = 4;

  typedef struct {
    logic [3:0] s_n;
    logic [3:0] r_n;
  } vec_t;

  typedef struct {
    int         mode;
    int         exp_cyc;
    logic       exp_rslt;
    logic [3:0] exp_mask;
    logic [2:0] exp_step;
  } scen_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   mode     = 0;
  int   cnt;

  vec_t  vecs [7];
  scen_t scens[3];

  logic [3:0] model_a = 4'b0000;
  logic [3:0] model_b = 4'b0000;
  logic       ch0_set_only = 1'b0;

  always #5 clk = ~clk;

  chip_sr_latch_tester_if #(.NUM_CH(NUM_CH)) bus_a ();
  chip_sr_latch_tester_if #(.NUM_CH(NUM_CH)) bus_b ();

  chip_sr_latch_tester #(.NUM_CH(NUM_CH), .SETTLE_CYC(4), .STOP_ON_FAIL(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  chip_sr_latch_tester #(.NUM_CH(NUM_CH), .SETTLE_CYC(4), .STOP_ON_FAIL(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // Behavioural 74279: S_n low forces Q=1 (dominant), else R_n low forces Q=0, else hold.
  always @(bus_a.drv_s_n or bus_a.drv_r_n) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!bus_a.drv_s_n[i]) model_a[i] = 1'b1;
      else if (!bus_a.drv_r_n[i]) model_a[i] = 1'b0;
    end
    if (!bus_a.drv_s_n[0]) ch0_set_only = 1'b1;
  end

  always @(bus_b.drv_s_n or bus_b.drv_r_n) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!bus_b.drv_s_n[i]) model_b[i] = 1'b1;
      else if (!bus_b.drv_r_n[i]) model_b[i] = 1'b0;
    end
  end

  always_comb begin
    bus_a.dut_q = model_a;
    case (mode)
      1: bus_a.dut_q[2] = 1'b0;
      2: bus_a.dut_q[0] = ch0_set_only;
      default: ;
    endcase
    bus_b.dut_q = model_b ^ 4'b1000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulses run, counts rising edges (including the one sampling run) until
  // done; checks the drive pair in the second SETTLE cycle of every step.
  task automatic run_a(input int max_cyc, input bit keep_run, output int n);
    @(negedge clk);
    bus_a.run = 1'b1;
    n = 0;
    while (n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
      bus_a.run       = keep_run;
      bus_a.disp_rslt = (n == 10);
      for (int k = 0; k < 7; k++) begin
        if (n == 4 + 6 * k) begin
          check($sformatf("drv_s_n_step%0d", k), bus_a.drv_s_n, vecs[k].s_n);
          check($sformatf("drv_r_n_step%0d", k), bus_a.drv_r_n, vecs[k].r_n);
        end
      end
      if (bus_a.done) break;
    end
    bus_a.disp_rslt = 1'b0;
    if (!bus_a.done) check("done_timeout", 0, 1);
  endtask

  task automatic ack_a;
    @(negedge clk);
    bus_a.disp_rslt = 1'b1;
    @(posedge clk);
    #1;
    bus_a.disp_rslt = 1'b0;
    check("done_after_ack", bus_a.done, 0);
  endtask

  initial begin
    vecs[0] = '{4'b0000, 4'b1111};
    vecs[1] = '{4'b1111, 4'b1111};
    vecs[2] = '{4'b1111, 4'b0000};
    vecs[3] = '{4'b1111, 4'b1111};
    vecs[4] = '{4'b0000, 4'b0000};
    vecs[5] = '{4'b1111, 4'b0000};
    vecs[6] = '{4'b0000, 4'b1111};

    scens[0] = '{0, 44, 1'b1, 4'b0000, 3'd7};
    scens[1] = '{1, 44, 1'b0, 4'b0100, 3'd0};
    scens[2] = '{2, 44, 1'b0, 4'b0001, 3'd2};

    rst             = 1'b1;
    bus_a.run       = 1'b0;
    bus_a.disp_rslt = 1'b0;
    bus_b.run       = 1'b0;
    bus_b.disp_rslt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", bus_a.done, 0);
    check("rst_rslt", bus_a.rslt, 0);
    check("rst_mask", bus_a.fail_mask, 0);
    check("rst_step", bus_a.fail_step, 7);
    check("rst_s_n", bus_a.drv_s_n, 4'b1111);
    check("rst_r_n", bus_a.drv_r_n, 4'b1111);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 3; s++) begin
      mode = scens[s].mode;
      run_a(100, 1'b0, cnt);
      check($sformatf("latency_s%0d", s), cnt, scens[s].exp_cyc);
      check($sformatf("rslt_s%0d", s), bus_a.rslt, scens[s].exp_rslt);
      check($sformatf("mask_s%0d", s), bus_a.fail_mask, scens[s].exp_mask);
      check($sformatf("fstep_s%0d", s), bus_a.fail_step, scens[s].exp_step);
      check($sformatf("drv_done_s%0d", s), {bus_a.drv_s_n, bus_a.drv_r_n}, 8'hFF);
      ack_a();
      check($sformatf("hold_rslt_s%0d", s), bus_a.rslt, scens[s].exp_rslt);
      check($sformatf("hold_mask_s%0d", s), bus_a.fail_mask, scens[s].exp_mask);
      check($sformatf("hold_fstep_s%0d", s), bus_a.fail_step, scens[s].exp_step);
    end

    // Early stop: channel 3 inverted fails at step 0.
    @(negedge clk);
    bus_b.run = 1'b1;
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      bus_b.run = 1'b0;
      if (bus_b.done) break;
    end
    check("b_latency", cnt, 8);
    check("b_rslt", bus_b.rslt, 0);
    check("b_mask", bus_b.fail_mask, 4'b1000);
    check("b_fstep", bus_b.fail_step, 0);
    check("b_drv_done", {bus_b.drv_s_n, bus_b.drv_r_n}, 8'hFF);

    // Reset during step 3 SETTLE (edge index 21), then a clean rerun.
    mode = 0;
    @(negedge clk);
    bus_a.run = 1'b1;
    repeat (22) begin
      @(posedge clk);
      #1;
      bus_a.run = 1'b0;
    end
    check("mid_rslt_before_rst", bus_a.rslt, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_done", bus_a.done, 0);
    check("mid_rst_drv", {bus_a.drv_s_n, bus_a.drv_r_n}, 8'hFF);
    check("mid_rst_rslt", bus_a.rslt, 0);
    check("mid_rst_fstep", bus_a.fail_step, 7);
    @(negedge clk);
    rst = 1'b0;
    run_a(100, 1'b0, cnt);
    check("rerun_latency", cnt, 44);
    check("rerun_rslt", bus_a.rslt, 1);
    check("rerun_mask", bus_a.fail_mask, 0);

    // run and disp_rslt together in DONE_S: one HALTED cycle, then run held high
    // for a whole test must not disturb the sequence.
    @(negedge clk);
    bus_a.run       = 1'b1;
    bus_a.disp_rslt = 1'b1;
    @(posedge clk);
    #1;
    bus_a.disp_rslt = 1'b0;
    check("both_done", bus_a.done, 0);
    check("both_drv", {bus_a.drv_s_n, bus_a.drv_r_n}, 8'hFF);
    run_a(100, 1'b1, cnt);
    check("keep_run_latency", cnt, 44);
    check("keep_run_rslt", bus_a.rslt, 1);
    repeat (3) @(posedge clk);
    #1;
    check("keep_run_done_held", bus_a.done, 1);
    @(negedge clk);
    bus_a.run = 1'b0;
    ack_a();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
